// File: rtl/wb_stage_pipe_pkg.sv
// wb_stage_pipe_pkg: opcode, writeback-source and load-size constants for the writeback stage
package wb_pkg;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_UJ = 2'b10} memtoreg_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_pipe_if.sv
// wb_stage_pipe_if: MEM-stage inputs and writeback/forwarding outputs of the writeback stage
interface wb_stage_pipe_if #(parameter int N = 32, parameter int RA_W = 5);
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [N-1:0]    alu_out;
  logic [N-1:0]    mem_out;
  logic [N-1:0]    return_addr;
  logic [N-1:0]    imm_out;
  logic [N-1:0]    pc_signed_offset;
  logic [1:0]      memtoreg;
  logic [6:0]      opcode_in;
  logic [2:0]      funct3_in;
  logic [1:0]      addr_lo;
  logic [RA_W-1:0] rd_in;
  logic            regwrite_in;
  logic            wb_valid;
  logic            wb_we;
  logic [RA_W-1:0] wb_rd;
  logic [N-1:0]    wb_data;
  logic            fwd_valid;
  logic [63:0]     instret;
  modport master (
    output in_valid, stall, flush, alu_out, mem_out, return_addr, imm_out, pc_signed_offset,
           memtoreg, opcode_in, funct3_in, addr_lo, rd_in, regwrite_in,
    input  wb_valid, wb_we, wb_rd, wb_data, fwd_valid, instret
  );
  modport slave (
    input  in_valid, stall, flush, alu_out, mem_out, return_addr, imm_out, pc_signed_offset,
           memtoreg, opcode_in, funct3_in, addr_lo, rd_in, regwrite_in,
    output wb_valid, wb_we, wb_rd, wb_data, fwd_valid, instret
  );
endinterface

// File: rtl/wb_stage_pipe_load_fmt.sv
// load_fmt: byte/half-word select and sign/zero extension of a raw memory read word
module load_fmt
  import wb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] mem_out,
  input  logic [2:0]   funct3,
  input  logic [1:0]   addr_lo,
  output logic [N-1:0] data
);
  if (N == 32) begin : g_fmt
    logic [7:0]  b;
    logic [15:0] h;
    assign b = mem_out[8*addr_lo +: 8];
    assign h = mem_out[16*addr_lo[1] +: 16];
    // sub-word loads are extended to the full word; unknown sizes fall back to the whole word
    always_comb
      data = funct3 == F3_LW  ? mem_out :
             funct3 == F3_LB  ? {{24{b[7]}}, b} :
             funct3 == F3_LBU ? {24'd0, b} :
             funct3 == F3_LH  ? {{16{h[15]}}, h} :
             funct3 == F3_LHU ? {16'd0, h} : mem_out;
  end else begin : g_pass
    assign data = mem_out;
  end
endmodule

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered writeback stage with source select, load formatting and forwarding; WB_INSTRET_EN adds a retired-instruction counter
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int N    = 32,
  parameter int RA_W = 5
) (
  input  logic clk,
  input  logic rst,
  wb_stage_pipe_if.slave bus
);
  logic [N-1:0]    ld_data, uj_data, src_data;
  logic            capture;
  logic            valid_d, valid_q, we_d, we_q;
  logic [RA_W-1:0] rd_d, rd_q;
  logic [N-1:0]    data_d, data_q;
  load_fmt #(.N(N)) u_load_fmt (
    .mem_out (bus.mem_out),
    .funct3  (bus.funct3_in),
    .addr_lo (bus.addr_lo),
    .data    (ld_data)
  );
  assign capture = !bus.flush && !bus.stall;
  // writeback source: U/J value by opcode, formatted load, or ALU (also for the reserved code)
  always_comb begin
    uj_data  = (bus.opcode_in == OP_JAL || bus.opcode_in == OP_JALR) ? bus.return_addr :
               bus.opcode_in == OP_LUI   ? bus.imm_out :
               bus.opcode_in == OP_AUIPC ? bus.pc_signed_offset : bus.alu_out;
    src_data = bus.memtoreg == WB_MEM ? ld_data :
               bus.memtoreg == WB_UJ  ? uj_data : bus.alu_out;
  end
  // flush kills the entry but keeps rd/data; stall freezes everything; otherwise capture
  always_comb begin
    valid_d = bus.flush ? 1'b0 : bus.stall ? valid_q : bus.in_valid;
    we_d    = bus.flush ? 1'b0 : bus.stall ? we_q :
              bus.in_valid && bus.regwrite_in && bus.rd_in != '0;
    rd_d    = capture ? bus.rd_in : rd_q;
    data_d  = capture ? src_data : data_q;
  end
  // writeback register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end
  assign bus.wb_valid  = valid_q;
  assign bus.wb_we     = we_q;
  assign bus.wb_rd     = rd_q;
  assign bus.wb_data   = data_q;
  assign bus.fwd_valid = valid_q & we_q;
`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;
  // counts valid instructions on capture edges, wrapping naturally at 2^64
  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else if (capture && bus.in_valid) instret_q <= instret_q + 64'd1;
  end
  assign bus.instret = instret_q;
`else
  assign bus.instret = '0;
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: table-driven and directed checks of the writeback stage
module tb_wb_stage_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_ir = 64'd0;
  always #5 clk = ~clk;
  wb_stage_pipe_if bus ();
  wb_stage_pipe dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [1:0]  m2r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [1:0]  al;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        iv;
    logic [31:0] ed;
    logic        ewe;
    logic        ev;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string n, input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({n, ".valid"}, 64'(bus.wb_valid), 64'(v));
    chk({n, ".we"}, 64'(bus.wb_we), 64'(we));
    chk({n, ".fwd"}, 64'(bus.fwd_valid), 64'(v & we));
    chk({n, ".rd"}, 64'(bus.wb_rd), 64'(rd));
    chk({n, ".data"}, 64'(bus.wb_data), 64'(d));
    chk({n, ".instret"}, bus.instret, exp_ir);
  endtask
  task automatic drive(input logic [1:0] m2r, input logic [6:0] op, input logic [2:0] f3, input logic [1:0] al,
                       input logic [31:0] alu, input logic [4:0] rd, input logic rw, input logic iv);
    bus.memtoreg    = m2r;
    bus.opcode_in   = op;
    bus.funct3_in   = f3;
    bus.addr_lo     = al;
    bus.alu_out     = alu;
    bus.rd_in       = rd;
    bus.regwrite_in = rw;
    bus.in_valid    = iv;
  endtask
  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.mem_out = 32'h8081_F2A3;
    bus.return_addr = 32'h0000_0104;
    bus.imm_out = 32'hABCD_E000;
    bus.pc_signed_offset = 32'h0000_2000;
    tv.push_back('{2'b01, 7'b0000011, 3'b000, 2'd0, 32'hDEAD_0001, 5'd1, 1'b1, 1'b1, 32'hFFFF_FFA3, 1'b1, 1'b1});
    tv.push_back('{2'b01, 7'b0000011, 3'b100, 2'd1, 32'hDEAD_0002, 5'd2, 1'b1, 1'b1, 32'h0000_00F2, 1'b1, 1'b1});
    tv.push_back('{2'b01, 7'b0000011, 3'b001, 2'd2, 32'hDEAD_0003, 5'd3, 1'b1, 1'b1, 32'hFFFF_8081, 1'b1, 1'b1});
    tv.push_back('{2'b01, 7'b0000011, 3'b101, 2'd0, 32'hDEAD_0004, 5'd4, 1'b1, 1'b1, 32'h0000_F2A3, 1'b1, 1'b1});
    tv.push_back('{2'b01, 7'b0000011, 3'b010, 2'd0, 32'hDEAD_0005, 5'd5, 1'b1, 1'b1, 32'h8081_F2A3, 1'b1, 1'b1});
    tv.push_back('{2'b01, 7'b0000011, 3'b001, 2'd3, 32'hDEAD_0006, 5'd6, 1'b1, 1'b1, 32'hFFFF_8081, 1'b1, 1'b1});
    tv.push_back('{2'b01, 7'b0000011, 3'b000, 2'd3, 32'hDEAD_0007, 5'd7, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b1});
    tv.push_back('{2'b01, 7'b0000011, 3'b011, 2'd1, 32'hDEAD_0008, 5'd8, 1'b1, 1'b1, 32'h8081_F2A3, 1'b1, 1'b1});
    tv.push_back('{2'b10, 7'b1101111, 3'b000, 2'd0, 32'hDEAD_0009, 5'd9, 1'b1, 1'b1, 32'h0000_0104, 1'b1, 1'b1});
    tv.push_back('{2'b10, 7'b1100111, 3'b000, 2'd0, 32'hDEAD_000A, 5'd10, 1'b1, 1'b1, 32'h0000_0104, 1'b1, 1'b1});
    tv.push_back('{2'b10, 7'b0110111, 3'b000, 2'd0, 32'hDEAD_000B, 5'd11, 1'b1, 1'b1, 32'hABCD_E000, 1'b1, 1'b1});
    tv.push_back('{2'b10, 7'b0010111, 3'b000, 2'd0, 32'hDEAD_000C, 5'd12, 1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b1});
    tv.push_back('{2'b10, 7'b0110011, 3'b000, 2'd0, 32'hDEAD_000D, 5'd13, 1'b1, 1'b1, 32'hDEAD_000D, 1'b1, 1'b1});
    tv.push_back('{2'b11, 7'b0010111, 3'b000, 2'd0, 32'hDEAD_000E, 5'd14, 1'b1, 1'b1, 32'hDEAD_000E, 1'b1, 1'b1});
    tv.push_back('{2'b00, 7'b1101111, 3'b000, 2'd0, 32'hDEAD_000F, 5'd15, 1'b1, 1'b1, 32'hDEAD_000F, 1'b1, 1'b1});
    tv.push_back('{2'b00, 7'b0110011, 3'b000, 2'd0, 32'h0000_0077, 5'd0, 1'b1, 1'b1, 32'h0000_0077, 1'b0, 1'b1});
    tv.push_back('{2'b00, 7'b0110011, 3'b000, 2'd0, 32'h0000_0099, 5'd3, 1'b1, 1'b0, 32'h0000_0099, 1'b0, 1'b0});
    tv.push_back('{2'b00, 7'b0100011, 3'b000, 2'd0, 32'h0000_00AA, 5'd4, 1'b0, 1'b1, 32'h0000_00AA, 1'b0, 1'b1});
    rst = 1'b1;
    drive(2'b00, 7'b0110011, 3'b000, 2'd0, 32'h0000_4321, 5'd9, 1'b1, 1'b1);
    step();
    step();
    chk_out("reset", 1'b0, 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    drive(2'b00, 7'b0110011, 3'b000, 2'd0, 32'h0000_1234, 5'd5, 1'b1, 1'b1);
    step();
`ifdef WB_INSTRET_EN
    exp_ir = 64'd1;
`endif
    chk_out("first", 1'b1, 1'b1, 5'd5, 32'h0000_1234);
    foreach (tv[i]) begin
      drive(tv[i].m2r, tv[i].op, tv[i].f3, tv[i].al, tv[i].alu, tv[i].rd, tv[i].rw, tv[i].iv);
      step();
`ifdef WB_INSTRET_EN
      if (tv[i].iv) exp_ir++;
`endif
      chk_out($sformatf("vec%0d", i), tv[i].ev, tv[i].ewe, tv[i].rd, tv[i].ed);
    end
    drive(2'b00, 7'b0110011, 3'b000, 2'd0, 32'h0000_0700, 5'd7, 1'b1, 1'b1);
    step();
`ifdef WB_INSTRET_EN
    exp_ir++;
`endif
    chk_out("cap7", 1'b1, 1'b1, 5'd7, 32'h0000_0700);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 7'b0000011, 3'(i), 2'(i), 32'h0000_0900 + 32'(i), 5'(20 + i), 1'(i), 1'b1);
      step();
      chk_out($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd7, 32'h0000_0700);
    end
    bus.flush = 1'b1;
    step();
    chk_out("flush_stall", 1'b0, 1'b0, 5'd7, 32'h0000_0700);
    bus.stall = 1'b0;
    drive(2'b00, 7'b0110011, 3'b000, 2'd0, 32'h0000_0AAA, 5'd2, 1'b1, 1'b1);
    step();
    chk_out("flush", 1'b0, 1'b0, 5'd7, 32'h0000_0700);
    bus.flush = 1'b0;
    step();
`ifdef WB_INSTRET_EN
    exp_ir++;
`endif
    chk_out("resume", 1'b1, 1'b1, 5'd2, 32'h0000_0AAA);
    for (int i = 0; i < 10; i++) begin
      drive(2'b00, 7'b0110011, 3'b000, 2'd0, 32'h0000_0100 + 32'(i), 5'(i + 1), 1'b1, 1'b1);
      step();
`ifdef WB_INSTRET_EN
      exp_ir++;
`endif
      chk($sformatf("cnt%0d.instret", i), bus.instret, exp_ir);
    end
`ifndef WB_INSTRET_EN
    chk("instret_off", bus.instret, 64'd0);
`else
    force dut.instret_q = '1;
    #1;
    release dut.instret_q;
    chk("instret_forced", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("instret_wrap", bus.instret, 64'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
